// File: rtl/audio_ring_fifo_ctrl.sv
// Ring FIFO controller for an external simple dual-port RAM, streaming through a 2-entry output buffer.
// Latency: a write in cycle w is visible as m_valid in cycle w+3 when empty; 1 word/cycle sustained.
// Backpressure: s_ready drops only when the RAM itself holds DEPTH words; m_ready low parks up to 2 words in the buffer.
module audio_ring_fifo_ctrl #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 9,
  parameter int AFULL_THRESH  = 960,
  parameter int AEMPTY_THRESH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int LW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
  logic                  fetch_pend_q, fetch_pend_d;
  buf_state_e            buf_q, buf_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  logic       wr;
  logic       pop;
  logic       fetch_go;
  logic       capture;
  logic [2:0] slots_used;

  assign m_valid = (buf_q != BUF_EMPTY);
  assign m_data  = head_q;

  assign ram_wr_en   = wr;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_wr_data = s_data;
  assign ram_rd_addr = rd_ptr_q;

  // Occupancy counts every word the block is responsible for, wherever it currently sits.
  assign level        = LW'(ram_count_q) + LW'(fetch_pend_q) + LW'(buf_q);
  assign almost_full  = (level >= LW'(AFULL_THRESH));
  assign almost_empty = (level <= LW'(AEMPTY_THRESH));

  // Handshake and fetch decisions; a fetch is issued only if its word will have a buffer slot on arrival.
  always_comb begin
    s_ready    = (ram_count_q < DEPTH_C) && !flush;
    wr         = s_valid && s_ready;
    pop        = m_valid && m_ready;
    slots_used = 3'(fetch_pend_q) + 3'(buf_q) - 3'(pop);
    fetch_go   = (ram_count_q != '0) && (slots_used < 3'd2) && !flush;
    capture    = fetch_pend_q && !flush;
  end

  // Pointer, RAM occupancy and in-flight fetch next state; flush returns everything to empty.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ram_count_d  = ram_count_q;
    fetch_pend_d = fetch_go;
    if (wr) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (fetch_go) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({wr, fetch_go})
      2'b10:   ram_count_d = ram_count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   ram_count_d = ram_count_q - (ADDR_WIDTH+1)'(1);
      default: ram_count_d = ram_count_q;
    endcase
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      ram_count_d  = '0;
      fetch_pend_d = 1'b0;
    end
  end

  // Output buffer next state: head_q is always the oldest word, tail_q the one behind it.
  always_comb begin
    buf_d  = buf_q;
    head_d = head_q;
    tail_d = tail_q;
    case (buf_q)
      BUF_EMPTY: begin
        if (capture) begin
          head_d = ram_rd_data;
          buf_d  = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (capture && pop) begin
          head_d = ram_rd_data;
        end else if (capture) begin
          tail_d = ram_rd_data;
          buf_d  = BUF_TWO;
        end else if (pop) begin
          buf_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          head_d = tail_q;
          buf_d  = BUF_ONE;
        end
      end
      default: buf_d = BUF_EMPTY;
    endcase
    if (flush) begin
      buf_d = BUF_EMPTY;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      fetch_pend_q <= 1'b0;
      buf_q        <= BUF_EMPTY;
      head_q       <= '0;
      tail_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      fetch_pend_q <= fetch_pend_d;
      buf_q        <= buf_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
    end
  end

  // A fetch landing while both entries are occupied would overwrite an unread sample.
  a_no_capture_in_two: assert property (@(posedge clk) disable iff (rst)
    !(fetch_pend_q && (buf_q == BUF_TWO)));

endmodule

// File: tb/tb_audio_ring_fifo_ctrl.sv
// Directed bench for audio_ring_fifo_ctrl with a behavioural 1024x9 RAM attached.
// Inputs change 1ns after each rising edge; outputs are checked 2ns after it.
// Each task covers one scenario and checks its own expected values.
module tb_audio_ring_fifo_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [8:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [8:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] level;
  logic        almost_full;
  logic        almost_empty;
  logic [8:0]  ram_wr_data;
  logic [9:0]  ram_wr_addr;
  logic        ram_wr_en;
  logic [9:0]  ram_rd_addr;
  logic [8:0]  ram_rd_data;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [8:0] mem [0:1023];
  logic [8:0] ram_rd_q;

  audio_ring_fifo_ctrl #(
    .ADDR_WIDTH(10), .DATA_WIDTH(9), .AFULL_THRESH(960), .AEMPTY_THRESH(32)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM: address sampled at the edge, data visible for the whole following cycle.
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_q <= mem[ram_rd_addr];
  end
  assign ram_rd_data = ram_rd_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_cnt++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else pass_cnt++;
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else pass_cnt++;
    chk_cnt++; if (level !== 12'd0) $display("FAIL reset_level: got %0d want 0", level); else pass_cnt++;
    chk_cnt++; if (almost_empty !== 1'b1) $display("FAIL reset_almost_empty: got %b want 1", almost_empty); else pass_cnt++;
    chk_cnt++; if (almost_full !== 1'b0) $display("FAIL reset_almost_full: got %b want 0", almost_full); else pass_cnt++;
    chk_cnt++; if (ram_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", ram_wr_en); else pass_cnt++;
    tick();
  endtask

  task automatic test_single();
    s_valid = 1'b1;
    s_data  = 9'h1A5;
    m_ready = 1'b1;
    #1;
    chk_cnt++; if (ram_wr_en !== 1'b1) $display("FAIL single_wr_en: got %b want 1", ram_wr_en); else pass_cnt++;
    chk_cnt++; if (ram_wr_addr !== 10'd0) $display("FAIL single_wr_addr: got %0d want 0", ram_wr_addr); else pass_cnt++;
    chk_cnt++; if (ram_wr_data !== 9'h1A5) $display("FAIL single_wr_data: got %h want 1a5", ram_wr_data); else pass_cnt++;
    tick();
    s_valid = 1'b0;
    #1;
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL single_c1_m_valid: got %b want 0", m_valid); else pass_cnt++;
    chk_cnt++; if (level !== 12'd1) $display("FAIL single_c1_level: got %0d want 1", level); else pass_cnt++;
    tick();
    #1;
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL single_c2_m_valid: got %b want 0", m_valid); else pass_cnt++;
    chk_cnt++; if (level !== 12'd1) $display("FAIL single_c2_level: got %0d want 1", level); else pass_cnt++;
    tick();
    #1;
    chk_cnt++; if (m_valid !== 1'b1) $display("FAIL single_c3_m_valid: got %b want 1", m_valid); else pass_cnt++;
    chk_cnt++; if (m_data !== 9'h1A5) $display("FAIL single_c3_m_data: got %h want 1a5", m_data); else pass_cnt++;
    tick();
    #1;
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL single_c4_m_valid: got %b want 0", m_valid); else pass_cnt++;
    chk_cnt++; if (level !== 12'd0) $display("FAIL single_c4_level: got %0d want 0", level); else pass_cnt++;
    m_ready = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    m_ready = 1'b0;
    for (int i = 0; i < 1026; i++) begin
      s_valid = 1'b1;
      s_data  = 9'(i);
      #1;
      chk_cnt++; if (s_ready !== 1'b1) $display("FAIL fill_s_ready[%0d]: got %b want 1", i, s_ready); else pass_cnt++;
      chk_cnt++; if (level !== 12'(i)) $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i); else pass_cnt++;
      chk_cnt++; if (almost_full !== (i >= 960)) $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, (i >= 960)); else pass_cnt++;
      chk_cnt++; if (almost_empty !== (i <= 32)) $display("FAIL fill_aempty[%0d]: got %b want %b", i, almost_empty, (i <= 32)); else pass_cnt++;
      tick();
    end
    s_valid = 1'b1;
    s_data  = 9'h077;
    #1;
    chk_cnt++; if (s_ready !== 1'b0) $display("FAIL full_s_ready: got %b want 0", s_ready); else pass_cnt++;
    chk_cnt++; if (ram_wr_en !== 1'b0) $display("FAIL full_wr_en: got %b want 0", ram_wr_en); else pass_cnt++;
    chk_cnt++; if (level !== 12'd1026) $display("FAIL full_level: got %0d want 1026", level); else pass_cnt++;
    chk_cnt++; if (almost_full !== 1'b1) $display("FAIL full_afull: got %b want 1", almost_full); else pass_cnt++;
    tick();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 1026; k++) begin
      #1;
      chk_cnt++; if (m_valid !== 1'b1) $display("FAIL drain_m_valid[%0d]: got %b want 1", k, m_valid); else pass_cnt++;
      chk_cnt++; if (m_data !== 9'(k)) $display("FAIL drain_m_data[%0d]: got %h want %h", k, m_data, 9'(k)); else pass_cnt++;
      chk_cnt++; if (level !== 12'(1026 - k)) $display("FAIL drain_level[%0d]: got %0d want %0d", k, level, 1026 - k); else pass_cnt++;
      tick();
    end
    #1;
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL drained_m_valid: got %b want 0", m_valid); else pass_cnt++;
    chk_cnt++; if (level !== 12'd0) $display("FAIL drained_level: got %0d want 0", level); else pass_cnt++;
    chk_cnt++; if (almost_empty !== 1'b1) $display("FAIL drained_aempty: got %b want 1", almost_empty); else pass_cnt++;
    m_ready = 1'b0;
    tick();
  endtask

  task automatic test_stream_wrap();
    int in_idx  = 0;
    int out_idx = 0;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 3010; cyc++) begin
      s_valid = (in_idx < 3000);
      s_data  = 9'((in_idx * 37 + 5) % 512);
      #1;
      chk_cnt++; if (level !== 12'(in_idx - out_idx)) $display("FAIL stream_level[%0d]: got %0d want %0d", cyc, level, in_idx - out_idx); else pass_cnt++;
      if (cyc >= 3 && cyc < 3003) begin
        chk_cnt++; if (m_valid !== 1'b1) $display("FAIL stream_gap[%0d]: m_valid got %b want 1", cyc, m_valid); else pass_cnt++;
      end
      if (m_valid && m_ready) begin
        chk_cnt++; if (m_data !== 9'((out_idx * 37 + 5) % 512)) $display("FAIL stream_data[%0d]: got %h want %h", out_idx, m_data, 9'((out_idx * 37 + 5) % 512)); else pass_cnt++;
        out_idx++;
      end
      if (s_valid && s_ready) in_idx++;
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk_cnt++; if (in_idx != 3000) $display("FAIL stream_in_count: got %0d want 3000", in_idx); else pass_cnt++;
    chk_cnt++; if (out_idx != 3000) $display("FAIL stream_out_count: got %0d want 3000", out_idx); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    int in_idx  = 0;
    int out_idx = 0;
    for (int cyc = 0; cyc < 3000 && out_idx < 400; cyc++) begin
      s_valid = (in_idx < 400);
      s_data  = 9'((in_idx * 11 + 100) % 512);
      m_ready = 1'($urandom_range(0, 1));
      #1;
      chk_cnt++; if (level !== 12'(in_idx - out_idx)) $display("FAIL bp_level[%0d]: got %0d want %0d", cyc, level, in_idx - out_idx); else pass_cnt++;
      chk_cnt++; if (level > 12'd1026) $display("FAIL bp_level_max[%0d]: got %0d want <=1026", cyc, level); else pass_cnt++;
      if (m_valid && m_ready) begin
        chk_cnt++; if (m_data !== 9'((out_idx * 11 + 100) % 512)) $display("FAIL bp_data[%0d]: got %h want %h", out_idx, m_data, 9'((out_idx * 11 + 100) % 512)); else pass_cnt++;
        out_idx++;
      end
      if (s_valid && s_ready) in_idx++;
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    chk_cnt++; if (out_idx != 400) $display("FAIL bp_out_count: got %0d want 400 within budget", out_idx); else pass_cnt++;
    chk_cnt++; if (level !== 12'd0) $display("FAIL bp_final_level: got %0d want 0", level); else pass_cnt++;
    tick();
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    for (int i = 0; i < 500; i++) begin
      s_valid = 1'b1;
      s_data  = 9'(i);
      tick();
    end
    s_valid = 1'b0;
    #1;
    chk_cnt++; if (level !== 12'd500) $display("FAIL flush_pre_level: got %0d want 500", level); else pass_cnt++;
    chk_cnt++; if (m_data !== 9'd0) $display("FAIL flush_pre_head: got %h want 0", m_data); else pass_cnt++;
    tick();
    // Pop and write together so a fetch is in flight on the next cycle.
    s_valid = 1'b1;
    s_data  = 9'h1FF;
    m_ready = 1'b1;
    tick();
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 9'h155;
    m_ready = 1'b1;
    #1;
    chk_cnt++; if (level !== 12'd500) $display("FAIL flush_cycle_level: got %0d want 500", level); else pass_cnt++;
    chk_cnt++; if (s_ready !== 1'b0) $display("FAIL flush_s_ready: got %b want 0", s_ready); else pass_cnt++;
    chk_cnt++; if (ram_wr_en !== 1'b0) $display("FAIL flush_wr_en: got %b want 0", ram_wr_en); else pass_cnt++;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    #1;
    chk_cnt++; if (level !== 12'd0) $display("FAIL post_flush_level: got %0d want 0", level); else pass_cnt++;
    chk_cnt++; if (m_valid !== 1'b0) $display("FAIL post_flush_m_valid: got %b want 0", m_valid); else pass_cnt++;
    chk_cnt++; if (s_ready !== 1'b1) $display("FAIL post_flush_s_ready: got %b want 1", s_ready); else pass_cnt++;
    tick();
    s_valid = 1'b1;
    s_data  = 9'h0AB;
    #1;
    chk_cnt++; if (ram_wr_en !== 1'b1) $display("FAIL post_flush_wr_en: got %b want 1", ram_wr_en); else pass_cnt++;
    chk_cnt++; if (ram_wr_addr !== 10'd0) $display("FAIL post_flush_wr_addr: got %0d want 0", ram_wr_addr); else pass_cnt++;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    #1;
    chk_cnt++; if (m_valid !== 1'b1) $display("FAIL post_flush_out_valid: got %b want 1", m_valid); else pass_cnt++;
    chk_cnt++; if (m_data !== 9'h0AB) $display("FAIL post_flush_out_data: got %h want 0ab", m_data); else pass_cnt++;
    tick();
    #1;
    chk_cnt++; if (level !== 12'd0) $display("FAIL post_flush_final_level: got %0d want 0", level); else pass_cnt++;
    m_ready = 1'b0;
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = 9'd0;
    m_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_stream_wrap();
    test_backpressure();
    test_flush();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
